// File: rtl/bus_arbiter.sv
// bus_arbiter
// Two-master arbiter in front of a single MemoryUnit bus. m0 (CPU) and m1
// (DMA) each own one pending slot that a one-cycle start pulse loads. A
// four-state FSM issues one transaction at a time and alternates between the
// masters when both are waiting. A watchdog abandons a transaction that never
// sees bus_done.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   m{0,1}_addr/data/we   request word address, write data, write enable
//   m{0,1}_start          one-cycle request pulse
//   m{0,1}_q / _done      read data (held) and one-cycle completion pulse
//   bus_addr/data/we      request toward the bus, stable from ISSUE to done
//   bus_start             one-cycle issue strobe
//   bus_q / bus_done      response from the bus
//   owner / busy          granted master (valid while busy) / FSM not idle
//   err_drop[1:0]         sticky: a start from master X was discarded
//   err_timeout           sticky: a transaction was abandoned by the watchdog
//
// state | meaning
// IDLE  | nothing in flight, arbitrate among pending/arriving requests
// ISSUE | bus_start high for one cycle, watchdog cleared
// WAIT  | waiting for bus_done or watchdog expiry
// RESP  | done pulse to the owner; may arbitrate straight into ISSUE
module bus_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] m0_addr,
  input  logic [31:0] m0_data,
  input  logic        m0_we,
  input  logic        m0_start,
  output logic [31:0] m0_q,
  output logic        m0_done,
  input  logic [26:0] m1_addr,
  input  logic [31:0] m1_data,
  input  logic        m1_we,
  input  logic        m1_start,
  output logic [31:0] m1_q,
  output logic        m1_done,
  output logic [26:0] bus_addr,
  output logic [31:0] bus_data,
  output logic        bus_we,
  output logic        bus_start,
  input  logic [31:0] bus_q,
  input  logic        bus_done,
  output logic        owner,
  output logic        busy,
  output logic [1:0]  err_drop,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] LP_WD_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_pend0, r_pend1;
  logic [26:0] r_slot0_addr, r_slot1_addr;
  logic [31:0] r_slot0_data, r_slot1_data;
  logic        r_slot0_we, r_slot1_we;
  logic        r_lastgrant;
  logic        r_owner;
  logic [15:0] r_wd;
  logic [26:0] r_bus_addr;
  logic [31:0] r_bus_data;
  logic        r_bus_we;
  logic [31:0] r_m0_q, r_m1_q;
  logic        r_m0_done, r_m1_done;
  logic [1:0]  r_err_drop;
  logic        r_err_timeout;

  logic        w_inflight;
  logic        w_acc0, w_acc1, w_drop0, w_drop1;
  logic        w_el0, w_el1;
  logic        w_arb, w_grant;
  logic        w_wd_hit, w_wait_exit, w_timeout;
  logic [26:0] w_src0_addr, w_src1_addr;
  logic [31:0] w_src0_data, w_src1_data;
  logic        w_src0_we, w_src1_we;

  // The owner's pend stays set through ISSUE/WAIT, so a repeat start from
  // the owner is caught by the pend test; in RESP its pend is already clear
  // and a fresh start is accepted.
  always_comb begin
    w_inflight  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    w_drop0     = m0_start && (r_pend0 || (w_inflight && !r_owner));
    w_drop1     = m1_start && (r_pend1 || (w_inflight && r_owner));
    w_acc0      = m0_start && !w_drop0;
    w_acc1      = m1_start && !w_drop1;
    w_el0       = r_pend0 || w_acc0;
    w_el1       = r_pend1 || w_acc1;
    w_arb       = ((r_state == S_IDLE) || (r_state == S_RESP)) && (w_el0 || w_el1);
    w_grant     = (w_el0 && w_el1) ? !r_lastgrant : w_el1;
    w_wd_hit    = (r_wd == LP_WD_LAST);
    w_wait_exit = (r_state == S_WAIT) && (bus_done || w_wd_hit);
    w_timeout   = (r_state == S_WAIT) && !bus_done && w_wd_hit;
    // A request arriving this cycle has not reached its slot yet.
    w_src0_addr = w_acc0 ? m0_addr : r_slot0_addr;
    w_src0_data = w_acc0 ? m0_data : r_slot0_data;
    w_src0_we   = w_acc0 ? m0_we   : r_slot0_we;
    w_src1_addr = w_acc1 ? m1_addr : r_slot1_addr;
    w_src1_data = w_acc1 ? m1_data : r_slot1_data;
    w_src1_we   = w_acc1 ? m1_we   : r_slot1_we;
  end

  // RESP arbitrates like IDLE so a queued request issues two cycles after
  // the previous bus_done instead of three.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_arb ? S_ISSUE : S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = w_wait_exit ? S_RESP : S_WAIT;
      S_RESP:  w_next = w_arb ? S_ISSUE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend0       <= 1'b0;
      r_pend1       <= 1'b0;
      r_slot0_addr  <= '0;
      r_slot0_data  <= '0;
      r_slot0_we    <= 1'b0;
      r_slot1_addr  <= '0;
      r_slot1_data  <= '0;
      r_slot1_we    <= 1'b0;
      r_lastgrant   <= 1'b1;
      r_owner       <= 1'b0;
      r_wd          <= '0;
      r_bus_addr    <= '0;
      r_bus_data    <= '0;
      r_bus_we      <= 1'b0;
      r_m0_q        <= '0;
      r_m1_q        <= '0;
      r_m0_done     <= 1'b0;
      r_m1_done     <= 1'b0;
      r_err_drop    <= 2'b00;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_wait_exit) begin
        if (r_owner) r_pend1 <= 1'b0;
        else         r_pend0 <= 1'b0;
      end
      if (w_acc0) begin
        r_pend0      <= 1'b1;
        r_slot0_addr <= m0_addr;
        r_slot0_data <= m0_data;
        r_slot0_we   <= m0_we;
      end
      if (w_acc1) begin
        r_pend1      <= 1'b1;
        r_slot1_addr <= m1_addr;
        r_slot1_data <= m1_data;
        r_slot1_we   <= m1_we;
      end
      if (w_drop0) r_err_drop[0] <= 1'b1;
      if (w_drop1) r_err_drop[1] <= 1'b1;
      if (w_timeout) r_err_timeout <= 1'b1;

      if (w_arb) begin
        r_owner     <= w_grant;
        r_lastgrant <= w_grant;
        r_bus_addr  <= w_grant ? w_src1_addr : w_src0_addr;
        r_bus_data  <= w_grant ? w_src1_data : w_src0_data;
        r_bus_we    <= w_grant ? w_src1_we   : w_src0_we;
      end

      if (r_state == S_ISSUE)     r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + 16'd1;

      r_m0_done <= w_wait_exit && !r_owner;
      r_m1_done <= w_wait_exit && r_owner;
      if (w_wait_exit) begin
        if (r_owner) r_m1_q <= bus_done ? bus_q : 32'd0;
        else         r_m0_q <= bus_done ? bus_q : 32'd0;
      end
    end
  end

  assign bus_addr    = r_bus_addr;
  assign bus_data    = r_bus_data;
  assign bus_we      = r_bus_we;
  assign bus_start   = (r_state == S_ISSUE);
  assign busy        = (r_state != S_IDLE);
  assign owner       = r_owner;
  assign m0_q        = r_m0_q;
  assign m1_q        = r_m1_q;
  assign m0_done     = r_m0_done;
  assign m1_done     = r_m1_done;
  assign err_drop    = r_err_drop;
  assign err_timeout = r_err_timeout;

endmodule
